// File: rtl/cam_pkg.sv
// Shared camera-capture definitions: frame geometry defaults and FSM states.
package cam_pkg;

    localparam int unsigned H_PIX_DEF   = 160;
    localparam int unsigned V_LINES_DEF = 120;
    localparam int unsigned AW_DEF      = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FRAME,
        ST_WAIT_LINE,
        ST_BYTE_HI,
        ST_BYTE_LO
    } cam_state_t;

endpackage

// File: rtl/rgb565_to_332.sv
// Combinational colour reduction of one camera pixel to an 8-bit framebuffer pixel.
module rgb565_to_332 (
    input  logic [15:0] rgb565,
    output logic [7:0]  rgb332
);

    // The framebuffer word is {high[7:5], high[2:0], low[4:3]}; the other bits are dropped.
    logic unused_bits;

    assign rgb332      = {rgb565[15:13], rgb565[10:8], rgb565[4:3]};
    assign unused_bits = ^{rgb565[12:11], rgb565[7:5], rgb565[2:0]};

endmodule

// File: rtl/cam_read.sv
// Camera byte-stream capture: pairs RGB565 bytes into RGB332 pixels and writes a framebuffer.
module cam_read
    import cam_pkg::*;
#(
    parameter int unsigned H_PIX   = H_PIX_DEF,
    parameter int unsigned V_LINES = V_LINES_DEF,
    parameter int unsigned AW      = AW_DEF
) (
    input  logic          reloj,
    input  logic          rst,
    input  logic          init,
    input  logic          VSYNC,
    input  logic          HREF,
    input  logic [7:0]    px_data,
    output logic [AW-1:0] mem_px_addr,
    output logic [7:0]    mem_px_data,
    output logic          px_wr,
    output logic          frame_done,
    output logic [7:0]    line_cnt,
    output logic          ovf
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(H_PIX * V_LINES - 1);

    cam_state_t state, state_nxt;

    logic       vsync_q, href_q;
    logic       vs_rise, vs_fall, href_fall;
    logic [7:0] hi_byte;
    logic [7:0] pix_332;
    logic       full;
    logic       in_capture;
    logic       take_hi, take_lo;
    logic       frame_start, frame_end;

    assign vs_rise   = VSYNC & ~vsync_q;
    assign vs_fall   = ~VSYNC & vsync_q;
    assign href_fall = ~HREF & href_q;

    rgb565_to_332 u_conv (
        .rgb565 ({hi_byte, px_data}),
        .rgb332 (pix_332)
    );

    // State register.
    always_ff @(posedge reloj) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle byte/frame decisions.
    // WAIT_LINE consumes the first byte of a line as the high byte, so the
    // state that follows it expects the low byte; BYTE_HI then handles every
    // later high byte of the line.
    always_comb begin
        state_nxt   = state;
        take_hi     = 1'b0;
        take_lo     = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        in_capture  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (init) state_nxt = ST_WAIT_FRAME;
            end
            ST_WAIT_FRAME: begin
                if (vs_fall) begin
                    frame_start = 1'b1;
                    state_nxt   = ST_WAIT_LINE;
                end
            end
            ST_WAIT_LINE: begin
                in_capture = 1'b1;
                if (vs_rise) begin
                    frame_end = 1'b1;
                    state_nxt = init ? ST_WAIT_FRAME : ST_IDLE;
                end else if (HREF && !VSYNC) begin
                    take_hi   = 1'b1;
                    state_nxt = ST_BYTE_LO;
                end
            end
            ST_BYTE_HI: begin
                in_capture = 1'b1;
                if (vs_rise) begin
                    frame_end = 1'b1;
                    state_nxt = init ? ST_WAIT_FRAME : ST_IDLE;
                end else if (HREF) begin
                    take_hi   = 1'b1;
                    state_nxt = ST_BYTE_LO;
                end else begin
                    state_nxt = ST_WAIT_LINE;
                end
            end
            ST_BYTE_LO: begin
                in_capture = 1'b1;
                // A pixel completed in the same cycle as VSYNC rising is still written.
                take_lo = HREF;
                if (vs_rise) begin
                    frame_end = 1'b1;
                    state_nxt = init ? ST_WAIT_FRAME : ST_IDLE;
                end else if (HREF) begin
                    state_nxt = ST_BYTE_HI;
                end else begin
                    state_nxt = ST_WAIT_LINE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Edge history, pixel assembly, write strobe, address, line count and overflow.
    always_ff @(posedge reloj) begin
        if (rst) begin
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            hi_byte     <= '0;
            mem_px_addr <= '0;
            mem_px_data <= '0;
            px_wr       <= 1'b0;
            frame_done  <= 1'b0;
            line_cnt    <= '0;
            ovf         <= 1'b0;
            full        <= 1'b0;
        end else begin
            vsync_q    <= VSYNC;
            href_q     <= HREF;
            px_wr      <= 1'b0;
            frame_done <= frame_end;

            if (take_hi) hi_byte <= px_data;

            if (take_lo) begin
                if (full) begin
                    ovf <= 1'b1;
                end else begin
                    px_wr       <= 1'b1;
                    mem_px_data <= pix_332;
                end
            end

            // Address advances after each write; the last slot is held and marks the frame full.
            if (px_wr) begin
                if (mem_px_addr == LAST_ADDR) begin
                    full <= 1'b1;
                end else begin
                    mem_px_addr <= mem_px_addr + 1'b1;
                end
            end

            if (in_capture && href_fall && line_cnt != '1) begin
                line_cnt <= line_cnt + 8'd1;
            end

            if (frame_start) begin
                mem_px_addr <= '0;
                line_cnt    <= '0;
                full        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cam_read.sv
// Directed bench for cam_read with a byte-level reference model and per-cycle output checking.
module tb_cam_read;

    logic        reloj;
    logic        rst;
    logic        init;
    logic        VSYNC;
    logic        HREF;
    logic [7:0]  px_data;
    logic [14:0] mem_px_addr;
    logic [7:0]  mem_px_data;
    logic        px_wr;
    logic        frame_done;
    logic [7:0]  line_cnt;
    logic        ovf;

    cam_read #(
        .H_PIX   (160),
        .V_LINES (120),
        .AW      (15)
    ) u_dut (
        .reloj       (reloj),
        .rst         (rst),
        .init        (init),
        .VSYNC       (VSYNC),
        .HREF        (HREF),
        .px_data     (px_data),
        .mem_px_addr (mem_px_addr),
        .mem_px_data (mem_px_data),
        .px_wr       (px_wr),
        .frame_done  (frame_done),
        .line_cnt    (line_cnt),
        .ovf         (ovf)
    );

    localparam int unsigned NPIX = 160 * 120;

    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    typedef struct {
        int unsigned addr;
        logic [7:0]  data;
        int unsigned stamp;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         cur;
    int unsigned passed = 0;
    int unsigned total  = 0;

    // Observed-output bookkeeping (compare process).
    int unsigned ncnt     = 0;
    int unsigned wr_cnt   = 0;
    int unsigned last_addr = 0;
    int unsigned done_cnt = 0;
    logic [7:0]  seen_data[$];
    logic        prev_done = 1'b0;
    logic        prev_wr   = 1'b0;

    // Reference model state.
    bit          m_armed, m_cap, m_hi_valid, m_ovf;
    bit          m_vs_prev, m_href_prev;
    logic [7:0]  m_hi;
    int unsigned m_addr, m_lines, exp_done;

    int unsigned w0, d0;
    logic [7:0]  col_bytes [6] = '{8'hF8, 8'h1F, 8'h07, 8'hE0, 8'h00, 8'h18};
    logic [7:0]  col_exp   [3] = '{8'hE3, 8'h1C, 8'h03};

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // RGB565 high/low bytes to RGB332 by arithmetic on the field positions.
    function automatic logic [7:0] model_conv(input int hi, input int lo);
        int r, g, b;
        r = hi / 32;
        g = hi % 8;
        b = (lo / 8) % 4;
        return 8'(r * 32 + g * 4 + b);
    endfunction

    function automatic void model_reset();
        m_armed = 0; m_cap = 0; m_hi_valid = 0; m_ovf = 0;
        m_addr = 0; m_lines = 0; m_hi = '0;
    endfunction

    // Present one cycle of camera inputs and advance the model with what the DUT samples.
    task automatic drive(input bit href_v, input logic [7:0] d, input bit vs_v);
        wr_t e;
        @(negedge reloj);
        #1;
        HREF = href_v; px_data = d; VSYNC = vs_v;
        if (m_cap && vs_v && !m_vs_prev) begin
            exp_done++;
            m_cap   = 0;
            m_armed = init;
        end else if (m_armed && !m_cap && m_vs_prev && !vs_v) begin
            m_cap = 1; m_addr = 0; m_lines = 0; m_hi_valid = 0;
        end else if (m_cap) begin
            if (href_v) begin
                if (!m_hi_valid) begin
                    m_hi = d; m_hi_valid = 1;
                end else begin
                    m_hi_valid = 0;
                    if (m_addr < NPIX) begin
                        e.addr = m_addr; e.data = model_conv(m_hi, d); e.stamp = ncnt + 1;
                        exp_q.push_back(e);
                        m_addr++;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end else if (m_href_prev) begin
                if (m_lines < 255) m_lines++;
                m_hi_valid = 0;
            end
        end
        m_vs_prev = vs_v; m_href_prev = href_v;
    endtask

    task automatic set_init(input bit v);
        @(negedge reloj);
        #1;
        init = v;
        if (v && !m_cap) m_armed = 1;
    endtask

    task automatic frame_begin();
        repeat (3) drive(1'b0, 8'h00, 1'b1);
        repeat (2) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic frame_end();
        repeat (4) drive(1'b0, 8'h00, 1'b1);
    endtask

    task automatic line_pat(input int unsigned nbytes, input int unsigned seed, input int unsigned gap);
        for (int unsigned b = 0; b < nbytes; b++) drive(1'b1, 8'(seed * 11 + b * 37 + 5), 1'b0);
        repeat (gap) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic checkpoint(input string tag);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        chk({tag, "_line_cnt"}, line_cnt, m_lines);
        chk({tag, "_ovf"}, ovf, m_ovf);
        chk({tag, "_frame_done_count"}, done_cnt, exp_done);
    endtask

    // Per-cycle output checking against the model's expected write stream.
    always @(negedge reloj) begin
        ncnt++;
        if (px_wr === 1'b1) begin
            wr_cnt++;
            last_addr = mem_px_addr;
            seen_data.push_back(mem_px_data);
            chk("wr_single_cycle", prev_wr, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", exp_q.size(), 1);
            end else begin
                cur = exp_q.pop_front();
                chk("wr_addr", mem_px_addr, cur.addr);
                chk("wr_data", mem_px_data, cur.data);
                chk("wr_latency", ncnt, cur.stamp);
            end
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            chk("frame_done_single_cycle", prev_done, 0);
        end
        prev_done = (frame_done === 1'b1);
        prev_wr   = (px_wr === 1'b1);
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; init = 1'b0; VSYNC = 1'b1; HREF = 1'b0; px_data = 8'h00;
        model_reset();
        m_vs_prev = 1; m_href_prev = 0; exp_done = 0;
        repeat (3) @(negedge reloj);
        #1;
        chk("rst_addr", mem_px_addr, 0);
        chk("rst_data", mem_px_data, 0);
        chk("rst_wr", px_wr, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_line_cnt", line_cnt, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;

        // Colour conversion on three hand-picked pixels.
        set_init(1'b1);
        seen_data.delete();
        frame_begin();
        for (int i = 0; i < 6; i++) drive(1'b1, col_bytes[i], 1'b0);
        repeat (2) drive(1'b0, 8'h00, 1'b0);
        frame_end();
        checkpoint("colour");
        chk("colour_count", seen_data.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("colour_value", (i < seen_data.size()) ? seen_data[i] : 8'h00, col_exp[i]);
        end
        chk("colour_lines", line_cnt, 1);

        // Odd-length line drops its trailing byte; next line continues the address.
        w0 = wr_cnt;
        frame_begin();
        line_pat(321, 1, 2);
        line_pat(4, 2, 2);
        frame_end();
        checkpoint("oddline");
        chk("oddline_writes", wr_cnt - w0, 162);
        chk("oddline_last_addr", last_addr, 161);
        chk("oddline_lines", line_cnt, 2);

        // Full frame.
        w0 = wr_cnt; d0 = done_cnt;
        frame_begin();
        for (int unsigned l = 0; l < 120; l++) line_pat(320, l, 1);
        frame_end();
        checkpoint("full");
        chk("full_writes", wr_cnt - w0, 19200);
        chk("full_last_addr", last_addr, 19199);
        chk("full_done", done_cnt - d0, 1);
        chk("full_lines", line_cnt, 120);
        chk("full_ovf", ovf, 0);

        // Reset after the high byte of pixel 50 of the second line.
        frame_begin();
        line_pat(4, 3, 2);
        line_pat(101, 4, 0);
        @(negedge reloj);
        #1;
        rst = 1'b1; init = 1'b0; px_data = 8'h5A;
        model_reset();
        @(negedge reloj);
        #1;
        chk("midrst_addr", mem_px_addr, 0);
        chk("midrst_data", mem_px_data, 0);
        chk("midrst_wr", px_wr, 0);
        chk("midrst_done", frame_done, 0);
        chk("midrst_line_cnt", line_cnt, 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_queue_empty", exp_q.size(), 0);
        rst = 1'b0; HREF = 1'b0; VSYNC = 1'b1; px_data = 8'h00;
        m_vs_prev = 1; m_href_prev = 0;
        // Idle after reset: a frame with init low is ignored.
        w0 = wr_cnt; d0 = done_cnt;
        frame_begin();
        line_pat(8, 5, 2);
        frame_end();
        chk("idle_writes", wr_cnt - w0, 0);
        chk("idle_done", done_cnt - d0, 0);
        checkpoint("idle");

        // init dropped mid-frame: frame completes, next frame ignored.
        set_init(1'b1);
        w0 = wr_cnt; d0 = done_cnt;
        frame_begin();
        line_pat(8, 6, 2);
        set_init(1'b0);
        line_pat(8, 7, 2);
        frame_end();
        checkpoint("initdrop");
        chk("initdrop_writes", wr_cnt - w0, 8);
        chk("initdrop_done", done_cnt - d0, 1);
        w0 = wr_cnt; d0 = done_cnt;
        frame_begin();
        line_pat(8, 8, 2);
        frame_end();
        chk("after_drop_writes", wr_cnt - w0, 0);
        chk("after_drop_done", done_cnt - d0, 0);

        // Over-long frame: writes stop at the last address and ovf sticks.
        set_init(1'b1);
        w0 = wr_cnt; d0 = done_cnt;
        frame_begin();
        for (int unsigned l = 0; l < 121; l++) line_pat(320, l + 9, 1);
        frame_end();
        checkpoint("overflow");
        chk("overflow_writes", wr_cnt - w0, 19200);
        chk("overflow_last_addr", last_addr, 19199);
        chk("overflow_addr_held", mem_px_addr, 19199);
        chk("overflow_flag", ovf, 1);
        chk("overflow_done", done_cnt - d0, 1);
        chk("overflow_lines", line_cnt, 121);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
